msim_client_axi_pull: RTL and testbench



---
 rtl/msim_client_axi_pull.sv | 247 ++++++++++++++++++++++++
 tb/tb_msim_client_axi_pull.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/msim_client_axi_pull.sv
// msim_client_axi_pull: simulation-side AXI4 manager that pulls AW/W/AR requests from a
// multisim server and pushes captured B/R responses back to it.
// Optional feature macro: MULTISIM_CLIENT_AXI_TRACE_EN (prints every local handshake
// and every accepted response push).
// msim_client_axi_pull_pkg provides the default payload types and an in-process server
// link with the same start/pull/push contract as the multisim client calls. Its scripted
// per-channel queues let the bridge run without an external server process.

package msim_client_axi_pull_pkg;
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } axi_aw_t;
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } axi_ar_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } axi_w_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } axi_b_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } axi_r_t;

    string     srv_dir;
    string     srv_name;
    bit        start_fail;
    int        start_calls;
    int        dpi_calls;
    int        reject_b;
    int        reject_r;
    bit [63:0] q_aw[$];
    bit [63:0] q_w[$];
    bit [63:0] q_ar[$];
    bit [63:0] q_b[$];
    bit [63:0] q_r[$];

    function automatic int chan_idx(string ch);
        int idx;
        idx = -1;
        if (ch == {srv_name, "_aw"}) idx = 0;
        else if (ch == {srv_name, "_w"}) idx = 1;
        else if (ch == {srv_name, "_ar"}) idx = 2;
        else if (ch == {srv_name, "_b"}) idx = 3;
        else if (ch == {srv_name, "_r"}) idx = 4;
        return idx;
    endfunction

    function automatic int multisim_client_start(string dir, string name);
        dpi_calls   = dpi_calls + 1;
        start_calls = start_calls + 1;
        srv_dir     = dir;
        srv_name    = name;
        return start_fail ? 0 : 1;
    endfunction

    function automatic int multisim_client_pull(string ch, output bit [63:0] d);
        int rc;
        rc = 0;
        d  = 64'd0;
        dpi_calls = dpi_calls + 1;
        case (chan_idx(ch))
            0: if (q_aw.size() > 0) begin d = q_aw.pop_front(); rc = 1; end
            1: if (q_w.size() > 0) begin d = q_w.pop_front(); rc = 1; end
            2: if (q_ar.size() > 0) begin d = q_ar.pop_front(); rc = 1; end
            default: rc = 0;
        endcase
        return rc;
    endfunction

    function automatic int multisim_client_push(string ch, input bit [63:0] d);
        int rc;
        rc = 0;
        dpi_calls = dpi_calls + 1;
        case (chan_idx(ch))
            3: if (reject_b > 0) reject_b = reject_b - 1; else begin q_b.push_back(d); rc = 1; end
            4: if (reject_r > 0) reject_r = reject_r - 1; else begin q_r.push_back(d); rc = 1; end
            default: rc = 0;
        endcase
        return rc;
    endfunction
endpackage

module msim_client_axi_pull
    import msim_client_axi_pull_pkg::*;
#(
    parameter type axi_aw_t = msim_client_axi_pull_pkg::axi_aw_t,
    parameter type axi_w_t  = msim_client_axi_pull_pkg::axi_w_t,
    parameter type axi_b_t  = msim_client_axi_pull_pkg::axi_b_t,
    parameter type axi_ar_t = msim_client_axi_pull_pkg::axi_ar_t,
    parameter type axi_r_t  = msim_client_axi_pull_pkg::axi_r_t
) (
    input  logic    clk,
    input  logic    rst,
    input  string   server_runtime_directory,
    input  string   server_name,
    output axi_aw_t o_axi_m_aw,
    output logic    o_axi_m_awvalid,
    input  logic    i_axi_m_awready,
    output axi_w_t  o_axi_m_w,
    output logic    o_axi_m_wvalid,
    input  logic    i_axi_m_wready,
    input  axi_b_t  i_axi_m_b,
    input  logic    i_axi_m_bvalid,
    output logic    o_axi_m_bready,
    output axi_ar_t o_axi_m_ar,
    output logic    o_axi_m_arvalid,
    input  logic    i_axi_m_arready,
    input  axi_r_t  i_axi_m_r,
    input  logic    i_axi_m_rvalid,
    output logic    o_axi_m_rready
);
    // started survives reset so the server link is opened only once per run
    bit      started_r;
    axi_aw_t aw_r;
    axi_w_t  w_r;
    axi_ar_t ar_r;
    axi_b_t  b_r;
    axi_r_t  r_r;
    logic    aw_valid_r, w_valid_r, ar_valid_r;
    logic    b_pend_r, r_pend_r, b_ready_r, r_ready_r;

    assign o_axi_m_aw      = aw_r;
    assign o_axi_m_awvalid = aw_valid_r;
    assign o_axi_m_w       = w_r;
    assign o_axi_m_wvalid  = w_valid_r;
    assign o_axi_m_ar      = ar_r;
    assign o_axi_m_arvalid = ar_valid_r;
    assign o_axi_m_bready  = b_ready_r;
    assign o_axi_m_rready  = r_ready_r;

    // Open the server link on the first edge out of reset; polling starts one edge later.
    always_ff @(posedge clk) begin
        if (!rst && !started_r) begin
            if (multisim_client_start(server_runtime_directory, server_name) == 0)
                $fatal(1, "msim_client_axi_pull: server start failed for %s", server_name);
            started_r <= 1'b1;
        end
    end

    // AW holding register: retire on handshake, refill from the server whenever free.
    always_ff @(posedge clk or posedge rst) begin : aw_chan
        bit [63:0] d;
        if (rst) begin
            aw_r <= '0;
            aw_valid_r <= 1'b0;
        end else begin
`ifdef MULTISIM_CLIENT_AXI_TRACE_EN
            if (aw_valid_r && i_axi_m_awready) $display("%t %s AW %h", $time, server_name, aw_r);
`endif
            if (aw_valid_r && i_axi_m_awready) aw_valid_r <= 1'b0;
            if (started_r && (!aw_valid_r || i_axi_m_awready)) begin
                if (multisim_client_pull({server_name, "_aw"}, d) == 1) begin
                    aw_r <= axi_aw_t'(d[$bits(axi_aw_t)-1:0]);
                    aw_valid_r <= 1'b1;
                end
            end
        end
    end

    // W holding register: same refill rule, so beats can stream one per cycle.
    always_ff @(posedge clk or posedge rst) begin : w_chan
        bit [63:0] d;
        if (rst) begin
            w_r <= '0;
            w_valid_r <= 1'b0;
        end else begin
`ifdef MULTISIM_CLIENT_AXI_TRACE_EN
            if (w_valid_r && i_axi_m_wready) $display("%t %s W %h", $time, server_name, w_r);
`endif
            if (w_valid_r && i_axi_m_wready) w_valid_r <= 1'b0;
            if (started_r && (!w_valid_r || i_axi_m_wready)) begin
                if (multisim_client_pull({server_name, "_w"}, d) == 1) begin
                    w_r <= axi_w_t'(d[$bits(axi_w_t)-1:0]);
                    w_valid_r <= 1'b1;
                end
            end
        end
    end

    // AR holding register: independent of the write channels.
    always_ff @(posedge clk or posedge rst) begin : ar_chan
        bit [63:0] d;
        if (rst) begin
            ar_r <= '0;
            ar_valid_r <= 1'b0;
        end else begin
`ifdef MULTISIM_CLIENT_AXI_TRACE_EN
            if (ar_valid_r && i_axi_m_arready) $display("%t %s AR %h", $time, server_name, ar_r);
`endif
            if (ar_valid_r && i_axi_m_arready) ar_valid_r <= 1'b0;
            if (started_r && (!ar_valid_r || i_axi_m_arready)) begin
                if (multisim_client_pull({server_name, "_ar"}, d) == 1) begin
                    ar_r <= axi_ar_t'(d[$bits(axi_ar_t)-1:0]);
                    ar_valid_r <= 1'b1;
                end
            end
        end
    end

    // B pending register: capture one response, retry the push until the server takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_r <= '0;
            b_pend_r <= 1'b0;
            b_ready_r <= 1'b0;
        end else if (b_pend_r) begin
            if (multisim_client_push({server_name, "_b"}, 64'(b_r)) == 1) begin
`ifdef MULTISIM_CLIENT_AXI_TRACE_EN
                $display("%t %s B push %h", $time, server_name, b_r);
`endif
                b_pend_r <= 1'b0;
                b_ready_r <= 1'b1;
            end else begin
                b_ready_r <= 1'b0;
            end
        end else if (b_ready_r && i_axi_m_bvalid) begin
`ifdef MULTISIM_CLIENT_AXI_TRACE_EN
            $display("%t %s B %h", $time, server_name, i_axi_m_b);
`endif
            b_r <= i_axi_m_b;
            b_pend_r <= 1'b1;
            b_ready_r <= 1'b0;
        end else begin
            b_ready_r <= 1'b1;
        end
    end

    // R pending register: one beat in flight, pushed in arrival order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r <= '0;
            r_pend_r <= 1'b0;
            r_ready_r <= 1'b0;
        end else if (r_pend_r) begin
            if (multisim_client_push({server_name, "_r"}, 64'(r_r)) == 1) begin
`ifdef MULTISIM_CLIENT_AXI_TRACE_EN
                $display("%t %s R push %h", $time, server_name, r_r);
`endif
                r_pend_r <= 1'b0;
                r_ready_r <= 1'b1;
            end else begin
                r_ready_r <= 1'b0;
            end
        end else if (r_ready_r && i_axi_m_rvalid) begin
`ifdef MULTISIM_CLIENT_AXI_TRACE_EN
            $display("%t %s R %h", $time, server_name, i_axi_m_r);
`endif
            r_r <= i_axi_m_r;
            r_pend_r <= 1'b1;
            r_ready_r <= 1'b0;
        end else begin
            r_ready_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_msim_client_axi_pull.sv
// Directed bench for msim_client_axi_pull, scripting the in-process server queues.
module tb_msim_client_axi_pull;
    import msim_client_axi_pull_pkg::*;

    logic    clk;
    logic    rst;
    string   srv_dir;
    string   srv;
    axi_aw_t aw_o;
    logic    awvalid, awready;
    axi_w_t  w_o;
    logic    wvalid, wready;
    axi_b_t  b_i;
    logic    bvalid, bready;
    axi_ar_t ar_o;
    logic    arvalid, arready;
    axi_r_t  r_i;
    logic    rvalid, rready;

    int n_checks;
    int n_fail;

    msim_client_axi_pull dut (
        .clk(clk), .rst(rst),
        .server_runtime_directory(srv_dir), .server_name(srv),
        .o_axi_m_aw(aw_o), .o_axi_m_awvalid(awvalid), .i_axi_m_awready(awready),
        .o_axi_m_w(w_o), .o_axi_m_wvalid(wvalid), .i_axi_m_wready(wready),
        .i_axi_m_b(b_i), .i_axi_m_bvalid(bvalid), .o_axi_m_bready(bready),
        .o_axi_m_ar(ar_o), .o_axi_m_arvalid(arvalid), .i_axi_m_arready(arready),
        .i_axi_m_r(r_i), .i_axi_m_rvalid(rvalid), .o_axi_m_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_outputs got %b want 00000", {awvalid, wvalid, arvalid, bready, rready});
        end
        n_checks++;
        if (dpi_calls !== 0) begin n_fail++; $display("FAIL reset_no_calls got %0d want 0", dpi_calls); end
        n_checks++;
        if (ar_o !== '0) begin n_fail++; $display("FAIL reset_payload got %h want 0", ar_o); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (start_calls !== 1) begin n_fail++; $display("FAIL start_once got %0d want 1", start_calls); end
        n_checks++;
        if (dpi_calls !== 1) begin n_fail++; $display("FAIL start_only_call got %0d want 1", dpi_calls); end
        n_checks++;
        if ({bready, rready} !== 2'b11) begin n_fail++; $display("FAIL ready_after_start got %b want 11", {bready, rready}); end
    endtask

    task automatic test_ar();
        axi_ar_t a;
        a = '0; a.addr = 32'h0000_1000; a.id = 4'd2;
        arready = 1'b1;
        q_ar.push_back(64'(a));
        @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || ar_o.addr !== 32'h0000_1000 || ar_o.id !== 4'd2) begin
            n_fail++; $display("FAIL ar_issue got v=%b addr=%h id=%0d want v=1 addr=00001000 id=2", arvalid, ar_o.addr, ar_o.id);
        end
        @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b0) begin n_fail++; $display("FAIL ar_one_cycle got %b want 0", arvalid); end
    endtask

    task automatic test_back_to_back();
        axi_ar_t a;
        for (int i = 0; i < 2; i++) begin
            a = '0; a.addr = 32'h0000_3000 + 32'(4 * i); a.id = 4'd5;
            q_ar.push_back(64'(a));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (i < 2) begin
                if (arvalid !== 1'b1 || ar_o.addr !== 32'h0000_3000 + 32'(4 * i)) begin
                    n_fail++; $display("FAIL ar_b2b_%0d got v=%b addr=%h", i, arvalid, ar_o.addr);
                end
            end else if (arvalid !== 1'b0) begin
                n_fail++; $display("FAIL ar_b2b_end got %b want 0", arvalid);
            end
        end
        arready = 1'b0;
    endtask

    task automatic test_write_burst();
        axi_aw_t a;
        axi_w_t  w;
        a = '0; a.addr = 32'h0000_2000; a.len = 8'd3; a.id = 4'd1;
        q_aw.push_back(64'(a));
        for (int j = 0; j < 4; j++) begin
            w.data = 32'h0000_00A0 + 32'(j); w.strb = 4'hF; w.last = (j == 3);
            q_w.push_back(64'(w));
        end
        awready = 1'b1;
        wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (wvalid !== 1'b1 || w_o.data !== 32'h0000_00A0 || w_o.last !== 1'b0) begin
                n_fail++; $display("FAIL w_hold_%0d got v=%b data=%h want v=1 data=000000a0", k, wvalid, w_o.data);
            end
            if (k == 0) begin
                n_checks++;
                if (awvalid !== 1'b1 || aw_o.addr !== 32'h0000_2000 || aw_o.len !== 8'd3) begin
                    n_fail++; $display("FAIL aw_issue got v=%b addr=%h len=%0d", awvalid, aw_o.addr, aw_o.len);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (awvalid !== 1'b0) begin n_fail++; $display("FAIL aw_done got %b want 0", awvalid); end
            end
        end
        wready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            n_checks++;
            if (j < 4) begin
                if (wvalid !== 1'b1 || w_o.data !== 32'h0000_00A0 + 32'(j) || w_o.last !== (j == 3)) begin
                    n_fail++; $display("FAIL w_beat_%0d got v=%b data=%h last=%b", j, wvalid, w_o.data, w_o.last);
                end
            end else if (wvalid !== 1'b0) begin
                n_fail++; $display("FAIL w_burst_end got %b want 0", wvalid);
            end
        end
        wready = 1'b0;
        awready = 1'b0;
    endtask

    task automatic test_b_resp();
        axi_b_t e;
        e.id = 4'd2; e.resp = 2'b00;
        reject_b = 2;
        b_i = e;
        bvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bvalid = 1'b0;
            n_checks++;
            if (bready !== (k == 3)) begin
                n_fail++; $display("FAIL b_ready_%0d got %b want %b", k, bready, (k == 3));
            end
        end
        n_checks++;
        if (q_b.size() !== 1) begin
            n_fail++; $display("FAIL b_push_count got %0d want 1", q_b.size());
        end else begin
            n_checks++;
            if (q_b[0] !== 64'(e)) begin n_fail++; $display("FAIL b_push_data got %h want %h", q_b[0], 64'(e)); end
        end
    endtask

    task automatic test_r_burst();
        axi_r_t e;
        int     waited;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (rready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
            if (waited >= 20) begin
                n_checks++; n_fail++; $display("FAIL r_ready_timeout beat %0d got 0 want 1", k);
            end
            e.id = 4'd1; e.data = 32'h0000_00D0 + 32'(k); e.resp = 2'b00; e.last = (k == 3);
            r_i = e;
            rvalid = 1'b1;
            @(negedge clk);
            rvalid = 1'b0;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (q_r.size() !== 4) begin
            n_fail++; $display("FAIL r_push_count got %0d want 4", q_r.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                e.id = 4'd1; e.data = 32'h0000_00D0 + 32'(k); e.resp = 2'b00; e.last = (k == 3);
                n_checks++;
                if (q_r[k] !== 64'(e)) begin n_fail++; $display("FAIL r_push_%0d got %h want %h", k, q_r[k], 64'(e)); end
            end
        end
    endtask

    task automatic test_reset_midop();
        axi_ar_t a;
        int      calls_at_rst;
        a = '0; a.addr = 32'h0000_4000; a.id = 4'd3;
        arready = 1'b0;
        q_ar.push_back(64'(a));
        @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pending got %b want 1", arvalid); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({arvalid, bready, rready} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_async got %b want 000", {arvalid, bready, rready});
        end
        calls_at_rst = dpi_calls;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dpi_calls !== calls_at_rst) begin n_fail++; $display("FAIL midrst_no_calls got %0d want %0d", dpi_calls, calls_at_rst); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (start_calls !== 1) begin n_fail++; $display("FAIL midrst_no_restart got %0d want 1", start_calls); end
        n_checks++;
        if (arvalid !== 1'b0 || dpi_calls <= calls_at_rst) begin
            n_fail++; $display("FAIL midrst_resume got v=%b calls=%0d want v=0 calls>%0d", arvalid, dpi_calls, calls_at_rst);
        end
        n_checks++;
        if (bready !== 1'b1) begin n_fail++; $display("FAIL midrst_bready got %b want 1", bready); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        srv_dir = "/tmp/msim"; srv = "cpu_3";
        rst = 1'b1;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; b_i = '0; r_i = '0;
        test_reset();
        test_ar();
        test_back_to_back();
        test_write_burst();
        test_b_resp();
        test_r_burst();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
